// File: rtl/ifu_pkg.sv
// ifu_pkg -- shared types and constants for the instruction fetch unit.
//   ifu_state_t : fetch FSM encoding (IDLE=0, RUN=1, HALTED=2)
//   instr_t     : 32-bit instruction word
//   iaddr_t     : 8-bit instruction word address
//   HALT_WORD_DEFAULT : encoding that stops fetch when captured
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } ifu_state_t;

  typedef logic [31:0] instr_t;
  typedef logic [7:0]  iaddr_t;

  localparam instr_t HALT_WORD_DEFAULT = 32'hFC00_0000;

endpackage

// File: rtl/ifu_pc_reg.sv
// ifu_pc_reg -- program counter flop with next-pc select.
// Ports:
//   clk, reset : clock, async active-high reset (pc <= RESET_PC)
//   load       : take target (highest priority)
//   incr       : advance by one, wrapping modulo 2^AW
//   target     : redirect address
//   pc         : current program counter
module ifu_pc_reg
  import ifu_pkg::*;
#(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          incr,
  input  logic [AW-1:0] target,
  output logic [AW-1:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (incr) begin
      pc <= pc + AW'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit -- fetch front end: owns the PC, reads the combinational
// instruction ROM and presents each word to decode through a valid/ready
// output register. Handles redirects, back-pressure, start and halt.
//
// Ports:
//   clk, reset     : clock, async active-high reset
//   start_i        : leave IDLE and begin fetching
//   imem_addr_o    : ROM word address (the pc flop)
//   imem_rdata_i   : ROM data for imem_addr_o, same cycle
//   instr_o        : registered instruction to decode
//   instr_pc_o     : address instr_o was fetched from
//   valid_o        : instr_o/instr_pc_o hold a valid word
//   ready_i        : decode accepts when valid_o && ready_i
//   redirect_i     : branch/jump taken, load target_i (ignored in IDLE)
//   target_i       : redirect address
//   halted_o       : FSM is in HALTED
//   state_o        : FSM state for debug
//   fetch_count_o  : accepted instructions, saturating (IFU_PERF_COUNT_EN)
//   flush_count_o  : redirects that flushed a valid word, saturating
//                    (IFU_PERF_COUNT_EN)
//
// Build option: define IFU_PERF_COUNT_EN to add the performance counters.
//
// state  | meaning
// IDLE   | no fetch, waiting for start_i
// RUN    | fetching one word per cycle while the output slot is free
// HALTED | halt word seen; waiting for a redirect to resume
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int            AW        = 8,
  parameter int            DW        = 32,
  parameter logic [AW-1:0] RESET_PC  = '0,
  parameter logic [DW-1:0] HALT_WORD = DW'(HALT_WORD_DEFAULT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  output logic [AW-1:0] imem_addr_o,
  input  logic [DW-1:0] imem_rdata_i,
  output logic [DW-1:0] instr_o,
  output logic [AW-1:0] instr_pc_o,
  output logic          valid_o,
  input  logic          ready_i,
  input  logic          redirect_i,
  input  logic [AW-1:0] target_i,
  output logic          halted_o,
  output logic [1:0]    state_o
`ifdef IFU_PERF_COUNT_EN
  ,
  output logic [15:0]   fetch_count_o,
  output logic [7:0]    flush_count_o
`endif
);

  ifu_state_t    state;
  logic [AW-1:0] pc;
  logic          slot_free;
  logic          redirect_act;
  logic          fetch;
  logic          halt_hit;

  assign slot_free    = !valid_o || ready_i;
  assign redirect_act = redirect_i && (state != IDLE);
  assign fetch        = (state == RUN) && !redirect_act && slot_free;
  assign halt_hit     = fetch && (imem_rdata_i == HALT_WORD);

  assign imem_addr_o  = pc;
  assign state_o      = state;

  // Halt word is delivered but the pc stays on it.
  ifu_pc_reg #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .reset  (reset),
    .load   (redirect_act),
    .incr   (fetch && !halt_hit),
    .target (target_i),
    .pc     (pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      halted_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state <= RUN;
          end
          halted_o <= 1'b0;
        end
        RUN: begin
          if (halt_hit) begin
            state    <= HALTED;
            halted_o <= 1'b1;
          end else begin
            halted_o <= 1'b0;
          end
        end
        HALTED: begin
          if (redirect_act) begin
            state    <= RUN;
            halted_o <= 1'b0;
          end else begin
            halted_o <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          halted_o <= 1'b0;
        end
      endcase
    end
  end

  // Redirect flushes the held word even under back-pressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_o    <= '0;
      instr_pc_o <= '0;
      valid_o    <= 1'b0;
    end else if (redirect_act) begin
      valid_o <= 1'b0;
    end else if (fetch) begin
      instr_o    <= imem_rdata_i;
      instr_pc_o <= pc;
      valid_o    <= 1'b1;
    end else if (slot_free) begin
      valid_o <= 1'b0;
    end
  end

`ifdef IFU_PERF_COUNT_EN
  // A word flushed by a redirect is not counted as accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_o <= '0;
      flush_count_o <= '0;
    end else begin
      if (valid_o && ready_i && !redirect_act && (fetch_count_o != 16'hFFFF)) begin
        fetch_count_o <= fetch_count_o + 16'd1;
      end
      if (redirect_act && valid_o && (flush_count_o != 8'hFF)) begin
        flush_count_o <= flush_count_o + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [7:0]  instr_pc_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [7:0]  target_i = 8'h00;
  logic        halted_o;
  logic [1:0]  state_o;

  logic [31:0] rom [256];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign imem_rdata_i = rom[imem_addr_o];

  instr_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .redirect_i   (redirect_i),
    .target_i     (target_i),
    .halted_o     (halted_o),
    .state_o      (state_o)
  );

  // Reset, then pulse start; returns at the negedge where state is RUN, pc=0.
  task automatic restart(input logic rdy);
    @(negedge clk);
    reset = 1'b1; start_i = 1'b0; redirect_i = 1'b0; ready_i = rdy;
    @(negedge clk);
    reset = 1'b0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    n_checks++; if (halted_o !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted_o); end
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    n_checks++; if (imem_addr_o !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h expected 00", imem_addr_o); end
    n_checks++; if (instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", instr_o); end
    n_checks++; if (instr_pc_o !== 8'h00) begin n_fail++; $display("FAIL reset_instr_pc: got %h expected 00", instr_pc_o); end
    @(negedge clk);
    reset = 1'b0; ready_i = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL idle_no_start_state: got %0d expected 0", state_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_no_start_valid: got %b expected 0", valid_o); end
    n_checks++; if (imem_addr_o !== 8'h00) begin n_fail++; $display("FAIL idle_no_start_pc: got %h expected 00", imem_addr_o); end
  endtask

  task automatic test_sequential;
    logic [31:0] exp [3];
    exp[0] = 32'h2001_0003; exp[1] = 32'h2002_0009; exp[2] = 32'h0022_1020;
    restart(1'b1);
    n_checks++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL seq_state_run: got %0d expected 1", state_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL seq_first_latency: got %b expected 0", valid_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (instr_o !== exp[i]) begin n_fail++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, instr_o, exp[i]); end
      n_checks++; if (instr_pc_o !== 8'(i)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, instr_pc_o, 8'(i)); end
      n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, valid_o); end
    end
  endtask

  task automatic test_back_pressure;
    restart(1'b1);
    @(negedge clk);
    @(negedge clk);
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (instr_o !== 32'h2002_0009) begin n_fail++; $display("FAIL bp_instr[%0d]: got %h expected 20020009", i, instr_o); end
      n_checks++; if (instr_pc_o !== 8'h01) begin n_fail++; $display("FAIL bp_instr_pc[%0d]: got %h expected 01", i, instr_pc_o); end
      n_checks++; if (imem_addr_o !== 8'h02) begin n_fail++; $display("FAIL bp_addr[%0d]: got %h expected 02", i, imem_addr_o); end
      n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, valid_o); end
    end
    ready_i = 1'b1;
    @(negedge clk);
    n_checks++; if (instr_pc_o !== 8'h02) begin n_fail++; $display("FAIL bp_release_pc: got %h expected 02", instr_pc_o); end
    n_checks++; if (instr_o !== 32'h0022_1020) begin n_fail++; $display("FAIL bp_release_instr: got %h expected 00221020", instr_o); end
    n_checks++; if (imem_addr_o !== 8'h03) begin n_fail++; $display("FAIL bp_release_addr: got %h expected 03", imem_addr_o); end
  endtask

  task automatic test_redirect_flush;
    restart(1'b1);
    @(negedge clk);
    ready_i = 1'b0; redirect_i = 1'b1; target_i = 8'h04;
    @(negedge clk);
    redirect_i = 1'b0; ready_i = 1'b1;
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", valid_o); end
    n_checks++; if (imem_addr_o !== 8'h04) begin n_fail++; $display("FAIL flush_addr: got %h expected 04", imem_addr_o); end
    @(negedge clk);
    n_checks++; if (instr_pc_o !== 8'h04) begin n_fail++; $display("FAIL flush_next_pc: got %h expected 04", instr_pc_o); end
    n_checks++; if (instr_o !== 32'h1000_0004) begin n_fail++; $display("FAIL flush_next_instr: got %h expected 10000004", instr_o); end
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_next_valid: got %b expected 1", valid_o); end
  endtask

  task automatic test_halt;
    restart(1'b1);
    repeat (4) @(negedge clk);
    n_checks++; if (instr_o !== 32'hFC00_0000) begin n_fail++; $display("FAIL halt_instr: got %h expected fc000000", instr_o); end
    n_checks++; if (instr_pc_o !== 8'h03) begin n_fail++; $display("FAIL halt_instr_pc: got %h expected 03", instr_pc_o); end
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL halt_delivered: got %b expected 1", valid_o); end
    n_checks++; if (halted_o !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b expected 1", halted_o); end
    n_checks++; if (imem_addr_o !== 8'h03) begin n_fail++; $display("FAIL halt_addr: got %h expected 03", imem_addr_o); end
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n_checks++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL halt_ignores_start: got %0d expected 2", state_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL halt_drained: got %b expected 0", valid_o); end
    n_checks++; if (imem_addr_o !== 8'h03) begin n_fail++; $display("FAIL halt_addr_hold: got %h expected 03", imem_addr_o); end
    redirect_i = 1'b1; target_i = 8'h00;
    @(negedge clk);
    redirect_i = 1'b0;
    n_checks++; if (halted_o !== 1'b0) begin n_fail++; $display("FAIL resume_halted: got %b expected 0", halted_o); end
    n_checks++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL resume_state: got %0d expected 1", state_o); end
    n_checks++; if (imem_addr_o !== 8'h00) begin n_fail++; $display("FAIL resume_addr: got %h expected 00", imem_addr_o); end
    @(negedge clk);
    n_checks++; if (instr_pc_o !== 8'h00) begin n_fail++; $display("FAIL resume_instr_pc: got %h expected 00", instr_pc_o); end
    n_checks++; if (instr_o !== 32'h2001_0003) begin n_fail++; $display("FAIL resume_instr: got %h expected 20010003", instr_o); end
  endtask

  task automatic test_wrap_and_reset;
    restart(1'b1);
    redirect_i = 1'b1; target_i = 8'hFF;
    @(negedge clk);
    redirect_i = 1'b0;
    n_checks++; if (imem_addr_o !== 8'hFF) begin n_fail++; $display("FAIL wrap_preload: got %h expected ff", imem_addr_o); end
    @(negedge clk);
    n_checks++; if (instr_pc_o !== 8'hFF) begin n_fail++; $display("FAIL wrap_pc_ff: got %h expected ff", instr_pc_o); end
    n_checks++; if (instr_o !== 32'h1000_00FF) begin n_fail++; $display("FAIL wrap_instr_ff: got %h expected 100000ff", instr_o); end
    n_checks++; if (imem_addr_o !== 8'h00) begin n_fail++; $display("FAIL wrap_addr: got %h expected 00", imem_addr_o); end
    @(negedge clk);
    n_checks++; if (instr_pc_o !== 8'h00) begin n_fail++; $display("FAIL wrap_pc_00: got %h expected 00", instr_pc_o); end
    n_checks++; if (instr_o !== 32'h2001_0003) begin n_fail++; $display("FAIL wrap_instr_00: got %h expected 20010003", instr_o); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", valid_o); end
    n_checks++; if (imem_addr_o !== 8'h00) begin n_fail++; $display("FAIL midrst_pc: got %h expected 00", imem_addr_o); end
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL midrst_state: got %0d expected 0", state_o); end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_no_fetch: got %b expected 0", valid_o); end
    n_checks++; if (imem_addr_o !== 8'h00) begin n_fail++; $display("FAIL midrst_pc_hold: got %h expected 00", imem_addr_o); end
    // start and redirect together in IDLE: start wins, pc unchanged
    start_i = 1'b1; redirect_i = 1'b1; target_i = 8'h09;
    @(negedge clk);
    start_i = 1'b0; redirect_i = 1'b0;
    n_checks++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL idle_start_redirect_state: got %0d expected 1", state_o); end
    n_checks++; if (imem_addr_o !== 8'h00) begin n_fail++; $display("FAIL idle_start_redirect_pc: got %h expected 00", imem_addr_o); end
    @(negedge clk);
    n_checks++; if (instr_pc_o !== 8'h00) begin n_fail++; $display("FAIL restart_instr_pc: got %h expected 00", instr_pc_o); end
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL restart_valid: got %b expected 1", valid_o); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h1000_0000 | 32'(i);
    rom[0] = 32'h2001_0003;
    rom[1] = 32'h2002_0009;
    rom[2] = 32'h0022_1020;
    rom[3] = 32'hFC00_0000;
    test_reset();
    test_sequential();
    test_back_pressure();
    test_redirect_flush();
    test_halt();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
